// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Widest word the receiver can assemble.
    localparam int DATA_MAX = 8;

    // Receive FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Word length select encoding (number of data bits = code + 5).
    typedef enum logic [1:0] {
        WLS_5 = 2'b00,
        WLS_6 = 2'b01,
        WLS_7 = 2'b10,
        WLS_8 = 2'b11
    } wls_t;

    // Index of the final data bit of a word for a given word length code.
    function automatic logic [2:0] last_bit_index(input logic [1:0] w);
        return {1'b0, w} + 3'd4;
    endfunction

endpackage

// File: rtl/dff.sv
// Generic resettable register bank, used as a multi-stage flop chain.
module dff #(
    parameter int                    FLOP_WIDTH  = 1,
    parameter logic [FLOP_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOP_WIDTH-1:0] d,
    output logic [FLOP_WIDTH-1:0] q
);

    // Plain register with asynchronous active-low reset to RESET_VALUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: synchronises the serial line, majority-votes each bit
// from three mid-bit samples and assembles 5..8 bit words with optional
// parity, reporting parity, framing and break conditions per word.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       rxd,
    input  logic       voting_edge,
    input  logic       sample_edge,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic       sample_clk_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       framing_err,
    output logic       break_int,
    output logic       rx_busy
);

    rx_state_t             state_reg;
    rx_state_t             state_next;
    logic [1:0]            sync_q;
    logic                  rxd_s;
    logic                  rxd_d_reg;
    logic [2:0]            vote_reg;
    logic                  bit_val;
    logic                  fall_edge;
    logic                  start_frame;
    logic                  data_sample;
    logic                  last_bit;
    logic                  sample_stop;
    logic [2:0]            bit_cnt_reg;
    logic [DATA_MAX-1:0]   shift_reg;
    logic [DATA_MAX-1:0]   bit_load;
    wls_t                  wls_reg;
    logic                  pen_reg;
    logic                  eps_reg;
    logic                  sp_reg;
    logic                  par_bit_reg;
    logic                  par_err_reg;
    logic                  exp_parity;

    // Two-stage synchroniser; the line idles high so both stages reset to 1.
    dff #(
        .FLOP_WIDTH  (2),
        .RESET_VALUE (2'b11)
    ) u_sync (
        .clk   (pclk),
        .rst_n (presetn),
        .d     ({sync_q[0], rxd}),
        .q     (sync_q)
    );

    assign rxd_s = sync_q[1];

    // One-cycle delayed copy of the synchronised line for edge detection.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rxd_d_reg <= 1'b1;
        end else begin
            rxd_d_reg <= rxd_s;
        end
    end

    assign fall_edge   = rxd_d_reg & ~rxd_s;
    assign start_frame = (state_reg == IDLE) && fall_edge;
    assign bit_val     = (vote_reg[0] & vote_reg[1]) |
                         (vote_reg[0] & vote_reg[2]) |
                         (vote_reg[1] & vote_reg[2]);
    assign data_sample = (state_reg == DATA) && sample_edge;
    assign last_bit    = (bit_cnt_reg == last_bit_index(wls_reg));
    assign sample_stop = (state_reg == STOP) && sample_edge;
    assign exp_parity  = sp_reg ? ~eps_reg : (eps_reg ? ^shift_reg : ~^shift_reg);

    assign sample_clk_clr = (state_reg == IDLE);
    assign rx_busy        = (state_reg != IDLE);

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; every bit decision happens on sample_edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fall_edge)   state_next = START;
            START:   if (sample_edge) state_next = bit_val ? IDLE : DATA;
            DATA:    if (sample_edge && last_bit) state_next = pen_reg ? PARITY : STOP;
            PARITY:  if (sample_edge) state_next = STOP;
            STOP:    if (sample_edge) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Vote shift register; sample_edge wins over a coincident voting_edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            vote_reg <= 3'b000;
        end else if (state_reg == IDLE || sample_edge) begin
            vote_reg <= 3'b000;
        end else if (voting_edge) begin
            vote_reg <= {vote_reg[1:0], rxd_s};
        end
    end

    // Frame configuration is frozen at the start edge; bit counter follows DATA.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wls_reg     <= WLS_5;
            pen_reg     <= 1'b0;
            eps_reg     <= 1'b0;
            sp_reg      <= 1'b0;
            bit_cnt_reg <= 3'd0;
        end else if (start_frame) begin
            wls_reg     <= wls_t'(wls);
            pen_reg     <= pen;
            eps_reg     <= eps;
            sp_reg      <= sp;
            bit_cnt_reg <= 3'd0;
        end else if (state_reg == START && sample_edge) begin
            bit_cnt_reg <= 3'd0;
        end else if (data_sample) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

    // Per-bit load enables: data arrives LSB first into position bit_cnt.
    for (genvar gi = 0; gi < DATA_MAX; gi++) begin : g_bit_load
        assign bit_load[gi] = data_sample && (bit_cnt_reg == 3'(gi));
    end

    // Word assembly; cleared at frame start so unused upper bits read 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            shift_reg <= '0;
        end else if (start_frame) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= (shift_reg & ~bit_load) | ({DATA_MAX{bit_val}} & bit_load);
        end
    end

    // Parity bit capture and comparison against the latched parity mode.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            par_bit_reg <= 1'b0;
            par_err_reg <= 1'b0;
        end else if (start_frame) begin
            par_bit_reg <= 1'b0;
            par_err_reg <= 1'b0;
        end else if (state_reg == PARITY && sample_edge) begin
            par_bit_reg <= bit_val;
            par_err_reg <= (bit_val != exp_parity);
        end
    end

    // Result registers: loaded on the stop-bit sample, held until the next word.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_valid    <= 1'b0;
            rx_data     <= 8'h00;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_int   <= 1'b0;
        end else begin
            rx_valid <= sample_stop;
            if (sample_stop) begin
                rx_data     <= shift_reg;
                parity_err  <= pen_reg & par_err_reg;
                framing_err <= ~bit_val;
                break_int   <= ~bit_val & ~(|shift_reg) & (~pen_reg | ~par_bit_reg);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a 16x baud tick model drives the
// voting/sample strobes, frames are built from random words and settings,
// and a word-level reference model predicts every rx_valid result.
module tb_uart_rx_core;

    localparam int BIT = 64;   // pclk cycles per bit (16 ticks x 4 cycles)

    logic       pclk = 1'b0;
    logic       presetn = 1'b1;
    logic       rxd = 1'b1;
    logic       voting_edge;
    logic       sample_edge;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp  = 1'b0;
    logic       sample_clk_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_int;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;
    int long_pulses = 0;
    int hold_viol = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];

    uart_rx_core dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .rxd            (rxd),
        .voting_edge    (voting_edge),
        .sample_edge    (sample_edge),
        .wls            (wls),
        .pen            (pen),
        .eps            (eps),
        .sp             (sp),
        .sample_clk_clr (sample_clk_clr),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_err     (parity_err),
        .framing_err    (framing_err),
        .break_int      (break_int),
        .rx_busy        (rx_busy)
    );

    always #5 pclk = ~pclk;

    // Baud tick model: a tick every 4 cycles, 16 ticks per bit, held cleared
    // while the receiver asks for it.
    logic [1:0] div_cnt = 2'd0;
    logic [3:0] tick_cnt = 4'd0;
    always @(posedge pclk) begin
        if (sample_clk_clr) begin
            div_cnt  <= 2'd0;
            tick_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
            if (div_cnt == 2'd3) tick_cnt <= tick_cnt + 4'd1;
        end
    end
    assign voting_edge = !sample_clk_clr && (div_cnt == 2'd3) && (tick_cnt >= 4'd5) && (tick_cnt <= 4'd7);
    assign sample_edge = !sample_clk_clr && (div_cnt == 2'd3) && (tick_cnt == 4'd8);

    // Output monitor: collects results, flags wide pulses and unrequested changes.
    logic prev_valid = 1'b0;
    rec_t last_out = '0;
    always @(negedge pclk) begin
        rec_t cur;
        cur = {rx_data, parity_err, framing_err, break_int};
        if (rx_valid === 1'b1) begin
            obs_q.push_back(cur);
            if (prev_valid) long_pulses++;
        end else if (presetn && cur !== last_out) begin
            hold_viol++;
        end
        last_out   = cur;
        prev_valid = rx_valid;
    end

    // Word-level reference: what the receiver should report for one frame.
    function automatic rec_t model_frame(input logic [7:0] d, input logic [1:0] w,
                                         input logic p, input logic e, input logic s,
                                         input logic flip, input logic stop,
                                         output logic par_sent);
        rec_t r;
        int nb;
        int ones;
        logic [7:0] m;
        logic ep;
        nb   = int'(w) + 5;
        m    = d & 8'((1 << nb) - 1);
        ones = $countones(m);
        if (s) ep = !e;
        else if (e) ep = (ones % 2 == 1);
        else ep = (ones % 2 == 0);
        par_sent = ep ^ flip;
        r.data = m;
        r.pe   = p && flip;
        r.fe   = !stop;
        r.bi   = !stop && (m == 8'h00) && (!p || !par_sent);
        return r;
    endfunction

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Drive one bit level for ncyc cycles; optionally invert it for one tick
    // so that only the 7th-tick vote sees the wrong level.
    task automatic hold_bit(input logic level, input int ncyc, input bit glitch);
        int countdown;
        int flip_left;
        countdown = -1;
        flip_left = 0;
        rxd = level;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge pclk);
            #1;
            if (flip_left > 0) flip_left--;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) flip_left = 4;
            end
            if (glitch && countdown < 0 && voting_edge && tick_cnt == 4'd5) countdown = 2;
            rxd = level ^ (flip_left > 0);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input logic flip,
                              input logic stop, input int glitch_bit, input bit tight);
        rec_t r;
        logic ps;
        int nb;
        int n;
        r = model_frame(d, w, p, e, s, flip, stop, ps);
        exp_q.push_back(r);
        wls = w; pen = p; eps = e; sp = s;
        hold_bit(1'b0, BIT, 1'b0);
        // Settings change mid-frame; the receiver must keep the frozen ones.
        wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); sp = 1'($urandom);
        nb = int'(w) + 5;
        for (int i = 0; i < nb; i++) hold_bit(d[i], BIT, glitch_bit == i);
        if (p) hold_bit(ps, BIT, 1'b0);
        if (tight) begin
            rxd = stop;
            n = 0;
            while (!sample_edge && n < 2 * BIT) begin
                @(posedge pclk);
                #1;
                n++;
            end
            checks++;
            if (n >= 2 * BIT) begin
                failures++;
                $display("FAIL tight_stop got=no_stop_sample_in_%0d_cycles want=stop_sample", n);
            end
            @(posedge pclk);
            #1;
        end else begin
            hold_bit(stop, BIT, 1'b0);
        end
    endtask

    task automatic test_reset;
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, framing_err, break_int} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%03h want=000", {rx_data, rx_valid, parity_err, framing_err, break_int});
        end
        checks++;
        if ({sample_clk_clr, rx_busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_status got=%b want=10", {sample_clk_clr, rx_busy});
        end
        presetn = 1'b1;
        idle(10);
        checks++;
        if ({rx_data, rx_valid, parity_err, framing_err, break_int, sample_clk_clr, rx_busy} !== 14'b00000000_0000_10) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=00000000000010",
                     {rx_data, rx_valid, parity_err, framing_err, break_int, sample_clk_clr, rx_busy});
        end
    endtask

    task automatic test_directed;
        rec_t e;
        rec_t o;
        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idle(20);
        send_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idle(20);
        send_frame(8'hA3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        idle(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL directed_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("directed frame data=%02h pe=%b fe=%b bi=%b", o.data, o.pe, o.fe, o.bi);
            if (o !== e) begin
                failures++;
                $display("FAIL directed_frame got data=%02h pe=%b fe=%b bi=%b want data=%02h pe=%b fe=%b bi=%b",
                         o.data, o.pe, o.fe, o.bi, e.data, e.pe, e.fe, e.bi);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        rec_t e;
        rec_t o;
        logic [7:0] d;
        d = 8'hC6;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        hold_bit(1'b0, BIT, 1'b0);
        for (int i = 0; i < 3; i++) hold_bit(d[i], BIT, 1'b0);
        hold_bit(d[3], 20, 1'b0);
        #2;
        presetn = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, framing_err, break_int, sample_clk_clr, rx_busy} !== 14'b00000000_0000_10) begin
            failures++;
            $display("FAIL reset_mid_frame got=%b want=00000000000010",
                     {rx_data, rx_valid, parity_err, framing_err, break_int, sample_clk_clr, rx_busy});
        end
        rxd = 1'b1;
        repeat (5) @(posedge pclk);
        #1;
        presetn = 1'b1;
        idle(2 * BIT);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL reset_abandon got=%0d_words want=0", obs_q.size());
        end
        obs_q.delete();
        send_frame(8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idle(20);
        checks++;
        if (obs_q.size() !== 1) begin
            failures++;
            $display("FAIL reset_next_count got=%0d want=1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("after-reset frame data=%02h pe=%b fe=%b bi=%b", o.data, o.pe, o.fe, o.bi);
            if (o !== e) begin
                failures++;
                $display("FAIL reset_next_frame got data=%02h pe=%b fe=%b bi=%b want data=%02h pe=%b fe=%b bi=%b",
                         o.data, o.pe, o.fe, o.bi, e.data, e.pe, e.fe, e.bi);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_glitch;
        rec_t e;
        rec_t o;
        int n;
        idle(10);
        hold_bit(1'b0, 16, 1'b0);
        checks++;
        if ({rx_busy, sample_clk_clr} !== 2'b10) begin
            failures++;
            $display("FAIL glitch_start got busy,clr=%b want=10", {rx_busy, sample_clk_clr});
        end
        rxd = 1'b1;
        n = 0;
        while (rx_busy && n < 2 * BIT) begin
            @(posedge pclk);
            #1;
            n++;
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_false_start got busy=%b want=0", rx_busy);
        end
        idle(BIT);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL glitch_no_valid got=%0d_words want=0", obs_q.size());
        end
        obs_q.delete();
        send_frame(8'hB4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        idle(10);
        send_frame(8'h4B, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0);
        idle(10);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL glitch_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("glitched frame data=%02h pe=%b fe=%b bi=%b", o.data, o.pe, o.fe, o.bi);
            if (o !== e) begin
                failures++;
                $display("FAIL glitch_frame got data=%02h pe=%b fe=%b bi=%b want data=%02h pe=%b fe=%b bi=%b",
                         o.data, o.pe, o.fe, o.bi, e.data, e.pe, e.fe, e.bi);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_break;
        rec_t e;
        rec_t o;
        logic ps;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        idle(10);
        e = model_frame(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ps);
        hold_bit(1'b0, 2 * 10 * BIT, 1'b0);
        checks++;
        if (obs_q.size() !== 1 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL break_single got words=%0d busy=%b want words=1 busy=0", obs_q.size(), rx_busy);
        end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            $display("break frame data=%02h pe=%b fe=%b bi=%b", o.data, o.pe, o.fe, o.bi);
            if (o !== e) begin
                failures++;
                $display("FAIL break_frame got data=%02h pe=%b fe=%b bi=%b want data=%02h pe=%b fe=%b bi=%b",
                         o.data, o.pe, o.fe, o.bi, e.data, e.pe, e.fe, e.bi);
            end
        end
        idle(BIT);
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL break_after_high got=%0d_words want=0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_random;
        rec_t e;
        rec_t o;
        logic [7:0] d;
        logic [1:0] w;
        logic p;
        int g;
        for (int k = 0; k < 24; k++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            w = 2'($urandom);
            p = 1'($urandom);
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(w) + 4)) : -1;
            send_frame(d, w, p, 1'($urandom), 1'($urandom), p & 1'($urandom),
                       $urandom_range(0, 3) != 0, g, 1'b0);
            idle(int'($urandom_range(8, 40)));
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("random frame data=%02h pe=%b fe=%b bi=%b", o.data, o.pe, o.fe, o.bi);
            if (o !== e) begin
                failures++;
                $display("FAIL random_frame got data=%02h pe=%b fe=%b bi=%b want data=%02h pe=%b fe=%b bi=%b",
                         o.data, o.pe, o.fe, o.bi, e.data, e.pe, e.fe, e.bi);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        rec_t e;
        rec_t o;
        logic [1:0] w;
        logic p;
        for (int k = 0; k < 5; k++) begin
            w = 2'($urandom);
            p = 1'($urandom);
            send_frame(8'($urandom), w, p, 1'($urandom), 1'($urandom), 1'b0, 1'b1, -1, k < 4);
        end
        idle(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            $display("back-to-back frame data=%02h pe=%b fe=%b bi=%b", o.data, o.pe, o.fe, o.bi);
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_frame got data=%02h pe=%b fe=%b bi=%b want data=%02h pe=%b fe=%b bi=%b",
                         o.data, o.pe, o.fe, o.bi, e.data, e.pe, e.fe, e.bi);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_pulse_and_hold;
        checks++;
        if (long_pulses !== 0) begin
            failures++;
            $display("FAIL valid_width got=%0d_wide_pulses want=0", long_pulses);
        end
        checks++;
        if (hold_viol !== 0) begin
            failures++;
            $display("FAIL output_hold got=%0d_changes_without_valid want=0", hold_viol);
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_directed;
        test_reset_mid_frame;
        test_glitch;
        test_break;
        test_random;
        test_back_to_back;
        test_pulse_and_hold;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have: pclk  input  1  sole clock; all flops posedge pclk.
REQ-002 SHALL have: presetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have: rxd  input  1  serial line, asynchronous to pclk, idle high.
REQ-004 SHALL have: voting_edge  input  1  one-cycle pulse at the 6th, 7th and 8th sub-bit ticks, from the baud clock generator.
REQ-005 SHALL have: sample_edge  input  1  one-cycle pulse at the 9th sub-bit tick, from the baud clock generator.
REQ-006 SHALL have: wls  input  2  word length select; 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 SHALL have: pen  input  1  parity enable.
REQ-008 SHALL have: eps  input  1  even parity select; 1=even, 0=odd.
REQ-009 SHALL have: sp  input  1  stick parity; expected parity bit = ~eps.
REQ-010 SHALL have: sample_clk_clr  output  1  holds the receive baud counter cleared.
REQ-011 SHALL have: rx_data  output  8  received word, right-justified, unused upper bits 0.
REQ-012 SHALL have: rx_valid  output  1  one-cycle pulse when rx_data and the error flags are valid.
REQ-013 SHALL have: parity_err, framing_err, break_int  output  1 each  status, valid with rx_valid.
REQ-014 SHALL have: rx_busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL synchronise rxd through 2 flops; all logic SHALL use the synchronised value rxd_s and its 1-cycle-delayed copy rxd_d.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE: sample_clk_clr=1; on rxd_d=1 and rxd_s=0 (falling edge) SHALL go to START next cycle; a line held low SHALL NOT retrigger.
REQ-018 Voting: each voting_edge SHALL shift rxd_s into a 3-bit vote register; each sample_edge SHALL evaluate bit = majority (>=2 ones) and clear the vote register.
REQ-019 START: on sample_edge, bit=1 -> false start, return to IDLE with no rx_valid; bit=0 -> DATA, bit_cnt=0.
REQ-020 DATA: on each sample_edge SHALL store bit LSB-first into bit position bit_cnt; after bit number wls+5 SHALL go to PARITY if pen, else to STOP.
REQ-021 PARITY: on sample_edge SHALL capture the parity bit; expected = sp ? ~eps : (eps ? ^data : ~^data); parity_err = captured != expected; then go to STOP.
REQ-022 STOP: on sample_edge SHALL check the first stop bit only; framing_err = (bit==0); break_int = (bit==0) & (data==0) & (parity bit==0 or !pen).
REQ-023 rx_valid SHALL pulse exactly 1 cycle, the cycle after the STOP sample_edge; rx_data and flags SHALL update in that same cycle and hold until the next rx_valid.
REQ-024 On the STOP sample_edge the FSM SHALL return to IDLE; a start edge arriving in the following cycle SHALL be accepted.
REQ-025 wls, pen, eps and sp SHALL be latched on IDLE->START and held constant for the rest of the frame.
REQ-026 sample_edge coinciding with voting_edge SHALL not occur; if it does, sample_edge SHALL take priority.

Reset
REQ-027 Reset SHALL force: state=IDLE, sync flops=1, vote=0, bit_cnt=0, rx_data=0x00, rx_valid=0, all error flags=0, sample_clk_clr=1, rx_busy=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no rx_valid; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-029 uart_pkg SHALL hold the rx state enum, the wls encoding, and the DATA_MAX=8 constant.
REQ-030 The 2-flop synchroniser SHALL be an instance of the existing dff (FLOP_WIDTH=2, RESET_VALUE=2'b11); no other sub-modules.

Verification
REQ-031 8N1, 0x55, clean line -> rx_data=0x55, rx_valid for 1 cycle, all error flags 0.
REQ-032 7E1 (wls=10, pen=1, eps=1), 0x41 sent with wrong parity bit 1 -> rx_data=0x41, parity_err=1.
REQ-033 8N1, 0xA3 with stop bit driven 0 -> framing_err=1, break_int=0.
REQ-034 Line held low for 2 full frames -> one rx_valid with rx_data=0x00, framing_err=1, break_int=1; no second frame until the line returns high.
REQ-035 Low glitch of 4 sub-bit ticks in IDLE -> START then IDLE, no rx_valid; 1-tick glitch on a data bit at the 7th tick -> bit still correct by majority.
REQ-036 presetn asserted during bit 3 of a frame -> outputs at reset values immediately; the next clean 5N1 frame 0x1F -> rx_data=0x1F.
